// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MDU_WAIT   = 2'd1,
      REDIR_PEND = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   typedef struct packed {
      logic        pc_en;
      stage_ctrl_t fd;
      stage_ctrl_t de;
      stage_ctrl_t em;
      stage_ctrl_t mw;
   } pipe_ctrl_t;

   localparam int REG_ZERO = 0;

   // A flushed stage loads zeros whatever its enable; BUBBLE keeps the slot moving.
   localparam stage_ctrl_t STAGE_HOLD   = '{en: 1'b0, flush: 1'b0};
   localparam stage_ctrl_t STAGE_ADV    = '{en: 1'b1, flush: 1'b0};
   localparam stage_ctrl_t STAGE_BUBBLE = '{en: 1'b1, flush: 1'b1};
   localparam stage_ctrl_t STAGE_CLEAR  = '{en: 1'b0, flush: 1'b1};

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use comparator between decode sources and EX load.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [REG_W-1:0] rd,
   input  logic             is_load,
   output logic             load_use
);

   assign load_use = is_load && (rd != REG_W'(REG_ZERO)) && ((rd == rs1) || (rd == rs2));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Enable/flush sequencing of PC and F/D, D/E, E/M, M/W registers.
//            Optional perf counters: define PIPE_HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int REG_W       = 5,
   parameter int MDU_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_stall,
   input  logic             d_stall,
   input  logic             mdu_start,
   input  logic             mdu_done,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_mispredict,
   input  logic [XLEN-1:0]  ex_target,
   output logic             pc_en,
   output logic             fd_en,
   output logic             fd_flush,
   output logic             de_en,
   output logic             de_flush,
   output logic             em_en,
   output logic             em_flush,
   output logic             mw_en,
   output logic             mw_flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             mdu_timeout
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0]      perf_lu,
   output logic [31:0]      perf_mdu,
   output logic [31:0]      perf_flush
`endif
);

   ctrl_state_t     state;
   ctrl_state_t     state_next;
   logic [XLEN-1:0] pend_pc;
   logic [XLEN-1:0] pend_pc_next;
   logic            load_use;
   logic            mdu_busy;
   pipe_ctrl_t      ctrl;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rd       (ex_rd),
      .is_load  (ex_is_load),
      .load_use (load_use)
   );

   assign mdu_busy = (state == MDU_WAIT) && !mdu_done;

   always_comb begin
      ctrl           = '{pc_en: 1'b0, fd: STAGE_HOLD, de: STAGE_HOLD, em: STAGE_HOLD, mw: STAGE_HOLD};
      redirect_valid = 1'b0;
      redirect_pc    = (state == REDIR_PEND) ? pend_pc : ex_target;
      state_next     = state;
      pend_pc_next   = pend_pc;

      if (reset) begin
         ctrl = '{pc_en: 1'b0, fd: STAGE_CLEAR, de: STAGE_CLEAR, em: STAGE_CLEAR, mw: STAGE_CLEAR};
      end else if (d_stall) begin
         // mdu_done is a single pulse, so it must be consumed even while M is stalled.
         ctrl.mw = STAGE_BUBBLE;
         if (state == MDU_WAIT && mdu_done) begin
            state_next = RUN;
         end
      end else if (mdu_busy) begin
         ctrl.em = STAGE_CLEAR;
         ctrl.mw = STAGE_ADV;
      end else if (ex_mispredict) begin
         ctrl.fd     = STAGE_BUBBLE;
         ctrl.de     = STAGE_BUBBLE;
         ctrl.em     = STAGE_ADV;
         ctrl.mw     = STAGE_ADV;
         redirect_pc = ex_target;
         if (i_stall) begin
            pend_pc_next = ex_target;
            state_next   = REDIR_PEND;
         end else begin
            ctrl.pc_en     = 1'b1;
            redirect_valid = 1'b1;
            state_next     = RUN;
         end
      end else if (state == REDIR_PEND) begin
         // D holds a bubble from the mispredict flush, so load-use cannot arise here.
         ctrl.fd = STAGE_BUBBLE;
         ctrl.de = STAGE_ADV;
         ctrl.em = STAGE_ADV;
         ctrl.mw = STAGE_ADV;
         if (!i_stall) begin
            ctrl.pc_en     = 1'b1;
            redirect_valid = 1'b1;
            state_next     = RUN;
         end
      end else begin
         if (load_use) begin
            ctrl.de = STAGE_BUBBLE;
            ctrl.em = STAGE_ADV;
            ctrl.mw = STAGE_ADV;
         end else if (i_stall) begin
            ctrl.fd = STAGE_BUBBLE;
            ctrl.de = STAGE_ADV;
            ctrl.em = STAGE_ADV;
            ctrl.mw = STAGE_ADV;
         end else begin
            ctrl = '{pc_en: 1'b1, fd: STAGE_ADV, de: STAGE_ADV, em: STAGE_ADV, mw: STAGE_ADV};
         end
         state_next = (state == RUN && mdu_start) ? MDU_WAIT : RUN;
      end
   end

   assign pc_en    = ctrl.pc_en;
   assign fd_en    = ctrl.fd.en;
   assign fd_flush = ctrl.fd.flush;
   assign de_en    = ctrl.de.en;
   assign de_flush = ctrl.de.flush;
   assign em_en    = ctrl.em.en;
   assign em_flush = ctrl.em.flush;
   assign mw_en    = ctrl.mw.en;
   assign mw_flush = ctrl.mw.flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         pend_pc <= '0;
      end else begin
         state   <= state_next;
         pend_pc <= pend_pc_next;
      end
   end

   generate
      if (MDU_TIMEOUT > 0) begin : g_timeout
         localparam int CNT_W = $clog2(MDU_TIMEOUT + 1);
         logic [CNT_W-1:0] busy_cnt;
         logic             tmo_flag;

         always_ff @(posedge clk) begin
            if (reset) begin
               busy_cnt <= '0;
               tmo_flag <= 1'b0;
            end else if (mdu_busy) begin
               if (busy_cnt != CNT_W'(MDU_TIMEOUT)) begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
               if (busy_cnt == CNT_W'(MDU_TIMEOUT - 1)) begin
                  tmo_flag <= 1'b1;
               end
            end else begin
               busy_cnt <= '0;
            end
         end

         assign mdu_timeout = tmo_flag;
      end else begin : g_no_timeout
         assign mdu_timeout = 1'b0;
      end
   endgenerate

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] lu_cnt;
   logic [31:0] mdu_cnt;
   logic [31:0] flush_cnt;

   // Only a load-use stall flushes D/E while leaving F/D intact; only MDU busy flushes E/M.
   always_ff @(posedge clk) begin
      if (reset) begin
         lu_cnt    <= '0;
         mdu_cnt   <= '0;
         flush_cnt <= '0;
      end else begin
         if (de_flush && !fd_flush && lu_cnt != 32'hFFFF_FFFF) begin
            lu_cnt <= lu_cnt + 32'd1;
         end
         if (em_flush && mdu_cnt != 32'hFFFF_FFFF) begin
            mdu_cnt <= mdu_cnt + 32'd1;
         end
         if ((fd_flush || de_flush || em_flush || mw_flush) && flush_cnt != 32'hFFFF_FFFF) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end

   assign perf_lu    = lu_cnt;
   assign perf_mdu   = mdu_cnt;
   assign perf_flush = flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Vector table, corner sequences and randomized model check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int XLEN  = 64;
   localparam int REG_W = 5;
   localparam int TMO   = 4;

   // {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush}
   localparam logic [8:0] P_RUN  = 9'b1_10_10_10_10;
   localparam logic [8:0] P_DST  = 9'b0_00_00_00_11;
   localparam logic [8:0] P_MDU  = 9'b0_00_00_01_10;
   localparam logic [8:0] P_MSP  = 9'b1_11_11_10_10;
   localparam logic [8:0] P_MSPI = 9'b0_11_11_10_10;
   localparam logic [8:0] P_LU   = 9'b0_00_11_10_10;
   localparam logic [8:0] P_IST  = 9'b0_11_10_10_10;
   localparam logic [8:0] P_RDR  = 9'b1_11_10_10_10;
   localparam logic [8:0] P_RST  = 9'b0_01_01_01_01;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_stall, d_stall, mdu_start, mdu_done;
   logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
   logic             ex_is_load, ex_mispredict;
   logic [XLEN-1:0]  ex_target;
   logic             pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush;
   logic             redirect_valid, mdu_timeout;
   logic [XLEN-1:0]  redirect_pc;
   logic [8:0]       ctrl;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .XLEN        (XLEN),
      .REG_W       (REG_W),
      .MDU_TIMEOUT (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_stall        (i_stall),
      .d_stall        (d_stall),
      .mdu_start      (mdu_start),
      .mdu_done       (mdu_done),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .ex_rd          (ex_rd),
      .ex_is_load     (ex_is_load),
      .ex_mispredict  (ex_mispredict),
      .ex_target      (ex_target),
      .pc_en          (pc_en),
      .fd_en          (fd_en),
      .fd_flush       (fd_flush),
      .de_en          (de_en),
      .de_flush       (de_flush),
      .em_en          (em_en),
      .em_flush       (em_flush),
      .mw_en          (mw_en),
      .mw_flush       (mw_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mdu_timeout    (mdu_timeout)
   );

   assign ctrl = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush};

   int passed = 0;
   int total  = 0;

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Compares at the falling edge, then advances to just after the next rising edge.
   task automatic expect_cyc(input string name, input logic [8:0] ec, input logic erv,
                             input logic [63:0] epc, input logic etmo);
      @(negedge clk);
      check_val({name, " ctrl"}, 64'(ctrl), 64'(ec));
      check_val({name, " redirect_valid"}, 64'(redirect_valid), 64'(erv));
      check_val({name, " mdu_timeout"}, 64'(mdu_timeout), 64'(etmo));
      if (erv) check_val({name, " redirect_pc"}, redirect_pc, epc);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; i_stall = 1'b0; d_stall = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ex_is_load = 1'b0; ex_mispredict = 1'b0;
      ex_target = 64'h0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      string            name;
      logic             ist, dst, ld, msp;
      logic [REG_W-1:0] rs1, rs2, rd;
      logic [8:0]       ec;
      logic             erv;
   } vec_t;

   vec_t tbl[13];

   // Reference model: pending MDU op, pending redirect, busy-cycle count, sticky timeout.
   bit              m_mdu, m_redir, m_tmo;
   int              m_busy;
   logic [XLEN-1:0] m_pc;

   task automatic model_expect(output logic [8:0] ec, output logic erv, output logic [63:0] epc);
      bit busy, lu;
      busy = m_mdu && !mdu_done;
      lu   = ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
      erv  = 1'b0;
      epc  = ex_target;
      if (reset)                 ec = P_RST;
      else if (d_stall)          ec = P_DST;
      else if (busy)             ec = P_MDU;
      else if (ex_mispredict) begin
         ec  = i_stall ? P_MSPI : P_MSP;
         erv = !i_stall;
      end else if (m_redir) begin
         ec  = i_stall ? P_IST : P_RDR;
         erv = !i_stall;
         epc = m_pc;
      end else if (lu)           ec = P_LU;
      else if (i_stall)          ec = P_IST;
      else                       ec = P_RUN;
   endtask

   task automatic model_advance();
      bit busy;
      busy = m_mdu && !mdu_done;
      if (reset) begin
         m_mdu = 0; m_redir = 0; m_tmo = 0; m_busy = 0; m_pc = '0;
      end else begin
         if (busy) begin
            m_busy++;
            if (m_busy >= TMO) m_tmo = 1;
         end else begin
            m_busy = 0;
         end
         if (d_stall) begin
            if (m_mdu && mdu_done) m_mdu = 0;
         end else if (!busy) begin
            if (ex_mispredict) begin
               m_mdu   = 0;
               m_redir = i_stall;
               if (i_stall) m_pc = ex_target;
            end else if (m_redir) begin
               if (!i_stall) m_redir = 0;
            end else begin
               m_mdu = !m_mdu && mdu_start;
            end
         end
      end
   endtask

   initial begin
      logic [63:0] tgt;
      logic [8:0]  ec;
      logic        erv;
      logic [63:0] epc;

      tbl[0]  = '{"normal",          0, 0, 0, 0, 5'd0, 5'd0, 5'd0, P_RUN, 0};
      tbl[1]  = '{"lu_rs2",          0, 0, 1, 0, 5'd1, 5'd5, 5'd5, P_LU,  0};
      tbl[2]  = '{"lu_rd_zero",      0, 0, 1, 0, 5'd0, 5'd0, 5'd0, P_RUN, 0};
      tbl[3]  = '{"lu_rs1",          0, 0, 1, 0, 5'd5, 5'd9, 5'd5, P_LU,  0};
      tbl[4]  = '{"load_no_match",   0, 0, 1, 0, 5'd5, 5'd6, 5'd7, P_RUN, 0};
      tbl[5]  = '{"nonload_match",   0, 0, 0, 0, 5'd5, 5'd5, 5'd5, P_RUN, 0};
      tbl[6]  = '{"istall",          1, 0, 0, 0, 5'd0, 5'd0, 5'd0, P_IST, 0};
      tbl[7]  = '{"dstall",          0, 1, 0, 0, 5'd0, 5'd0, 5'd0, P_DST, 0};
      tbl[8]  = '{"dstall_misp",     0, 1, 0, 1, 5'd0, 5'd0, 5'd0, P_DST, 0};
      tbl[9]  = '{"misp",            0, 0, 0, 1, 5'd0, 5'd0, 5'd0, P_MSP, 1};
      tbl[10] = '{"misp_over_lu",    0, 0, 1, 1, 5'd3, 5'd0, 5'd3, P_MSP, 1};
      tbl[11] = '{"lu_over_istall",  1, 0, 1, 0, 5'd0, 5'd4, 5'd4, P_LU,  0};
      tbl[12] = '{"dstall_over_all", 1, 1, 1, 0, 5'd4, 5'd0, 5'd4, P_DST, 0};

      idle();
      reset = 1'b1;
      expect_cyc("reset_state", P_RST, 0, 64'h0, 0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         do_reset();
         tgt           = {$urandom, $urandom};
         i_stall       = tbl[i].ist;
         d_stall       = tbl[i].dst;
         ex_is_load    = tbl[i].ld;
         ex_mispredict = tbl[i].msp;
         id_rs1        = tbl[i].rs1;
         id_rs2        = tbl[i].rs2;
         ex_rd         = tbl[i].rd;
         ex_target     = tgt;
         expect_cyc(tbl[i].name, tbl[i].ec, tbl[i].erv, tgt, 0);
      end

      // MDU issue, three busy cycles, done cycle advances.
      do_reset();
      mdu_start = 1'b1;
      expect_cyc("mdu_issue", P_RUN, 0, 64'h0, 0);
      mdu_start = 1'b0;
      for (int i = 0; i < 3; i++) expect_cyc("mdu_busy", P_MDU, 0, 64'h0, 0);
      mdu_done = 1'b1;
      expect_cyc("mdu_done", P_RUN, 0, 64'h0, 0);
      mdu_done = 1'b0;
      expect_cyc("mdu_after", P_RUN, 0, 64'h0, 0);

      // Mispredict under I-miss, redirect once fetch resumes.
      do_reset();
      ex_mispredict = 1'b1; ex_target = 64'h8000_0100; i_stall = 1'b1;
      expect_cyc("misp_imiss", P_MSPI, 0, 64'h0, 0);
      ex_mispredict = 1'b0; ex_target = 64'hDEAD_BEEF_0000_0000;
      expect_cyc("redir_wait1", P_IST, 0, 64'h0, 0);
      expect_cyc("redir_wait2", P_IST, 0, 64'h0, 0);
      i_stall = 1'b0;
      expect_cyc("redir_fire", P_RDR, 1, 64'h8000_0100, 0);
      expect_cyc("redir_after", P_RUN, 0, 64'h0, 0);

      // d_stall holds a pending redirect.
      do_reset();
      ex_mispredict = 1'b1; ex_target = 64'h0000_0000_1234_5678; i_stall = 1'b1;
      expect_cyc("pend_set", P_MSPI, 0, 64'h0, 0);
      ex_mispredict = 1'b0; i_stall = 1'b0; d_stall = 1'b1;
      expect_cyc("pend_dstall", P_DST, 0, 64'h0, 0);
      d_stall = 1'b0;
      expect_cyc("pend_release", P_RDR, 1, 64'h0000_0000_1234_5678, 0);

      // Mispredict held off by d_stall, exactly one redirect afterwards.
      do_reset();
      ex_mispredict = 1'b1; ex_target = 64'h0000_0000_0000_4440; d_stall = 1'b1;
      expect_cyc("dmisp_1", P_DST, 0, 64'h0, 0);
      expect_cyc("dmisp_2", P_DST, 0, 64'h0, 0);
      d_stall = 1'b0;
      expect_cyc("dmisp_fire", P_MSP, 1, 64'h0000_0000_0000_4440, 0);
      ex_mispredict = 1'b0;
      expect_cyc("dmisp_after", P_RUN, 0, 64'h0, 0);

      // Timeout after TMO busy cycles; sticky until reset.
      do_reset();
      mdu_start = 1'b1;
      expect_cyc("tmo_issue", P_RUN, 0, 64'h0, 0);
      mdu_start = 1'b0;
      for (int i = 0; i < TMO; i++) expect_cyc("tmo_busy_pre", P_MDU, 0, 64'h0, 0);
      expect_cyc("tmo_set", P_MDU, 0, 64'h0, 1);
      expect_cyc("tmo_hold", P_MDU, 0, 64'h0, 1);
      mdu_done = 1'b1;
      expect_cyc("tmo_done", P_RUN, 0, 64'h0, 1);
      mdu_done = 1'b0;
      expect_cyc("tmo_sticky", P_RUN, 0, 64'h0, 1);
      reset = 1'b1;
      expect_cyc("tmo_reset", P_RST, 0, 64'h0, 1);
      reset = 1'b0;
      expect_cyc("tmo_cleared", P_RUN, 0, 64'h0, 0);

      // Reset in MDU_WAIT and in REDIR_PEND.
      do_reset();
      mdu_start = 1'b1;
      expect_cyc("rst_mdu_issue", P_RUN, 0, 64'h0, 0);
      mdu_start = 1'b0;
      expect_cyc("rst_mdu_busy", P_MDU, 0, 64'h0, 0);
      reset = 1'b1;
      expect_cyc("rst_mdu_reset", P_RST, 0, 64'h0, 0);
      reset = 1'b0;
      expect_cyc("rst_mdu_run1", P_RUN, 0, 64'h0, 0);
      expect_cyc("rst_mdu_run2", P_RUN, 0, 64'h0, 0);
      ex_mispredict = 1'b1; ex_target = 64'h0000_0000_0000_0A00; i_stall = 1'b1;
      expect_cyc("rst_pend_set", P_MSPI, 0, 64'h0, 0);
      ex_mispredict = 1'b0; i_stall = 1'b0; reset = 1'b1;
      expect_cyc("rst_pend_reset", P_RST, 0, 64'h0, 0);
      reset = 1'b0;
      expect_cyc("rst_pend_drop", P_RUN, 0, 64'h0, 0);

      // Randomized run against the reference model.
      do_reset();
      m_mdu = 0; m_redir = 0; m_tmo = 0; m_busy = 0; m_pc = '0;
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 199) == 0);
         i_stall       = ($urandom_range(0, 3) == 0);
         d_stall       = ($urandom_range(0, 4) == 0);
         mdu_start     = ($urandom_range(0, 11) == 0);
         mdu_done      = m_mdu ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
         ex_is_load    = $urandom_range(0, 1) == 1;
         ex_rd         = REG_W'($urandom_range(0, 3));
         id_rs1        = REG_W'($urandom_range(0, 3));
         id_rs2        = REG_W'($urandom_range(0, 3));
         ex_mispredict = ($urandom_range(0, 9) == 0);
         ex_target     = {$urandom, $urandom};
         @(negedge clk);
         model_expect(ec, erv, epc);
         check_val("rand ctrl", 64'(ctrl), 64'(ec));
         check_val("rand redirect_valid", 64'(redirect_valid), 64'(erv));
         check_val("rand mdu_timeout", 64'(mdu_timeout), 64'(m_tmo));
         if (erv) check_val("rand redirect_pc", redirect_pc, epc);
         model_advance();
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
